// File: rtl/commit_probe_pkg.sv
// Shared types and constants for the commit probe.
// Optional trace buffer (TRACE_DEPTH) is used only when COMMIT_PROBE_TRACE_EN is defined.
package commit_probe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [4:0]  REG_A0      = 5'd10;
  localparam int          TRACE_DEPTH = 8;

endpackage

// File: rtl/commit_probe_if.sv
// In-order commit stream from the core into the probe.
// Same interface with or without COMMIT_PROBE_TRACE_EN.
interface commit_probe_if #(
  parameter int XLEN = 64
);
  logic            cmt_valid;
  logic            cmt_ready;
  logic [XLEN-1:0] cmt_pc;
  logic [31:0]     cmt_inst;
  logic            cmt_wen;
  logic [4:0]      cmt_rd;
  logic [XLEN-1:0] cmt_wdata;

  modport master (
    output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata,
    input  cmt_ready
  );

  modport slave (
    input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata,
    output cmt_ready
  );
endinterface

// File: rtl/commit_probe_gprs.sv
// Shadow architectural register file with x0 hard-wired to zero and a flat read-out.
// Unaffected by COMMIT_PROBE_TRACE_EN.
module commit_probe_gprs #(
  parameter int XLEN   = 64,
  parameter int NR_GPR = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [4:0]             i_rd,
  input  logic [XLEN-1:0]        i_wdata,
  output logic [NR_GPR*XLEN-1:0] o_rf_flat
);

  assign o_rf_flat[XLEN-1:0] = '0;

  for (genvar i = 1; i < NR_GPR; i++) begin : g_reg
    logic [XLEN-1:0] r_gpr;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_gpr <= '0;
      end else if (i_we && (i_rd == 5'(i))) begin
        r_gpr <= i_wdata;
      end
    end

    assign o_rf_flat[i*XLEN +: XLEN] = r_gpr;
  end

endmodule

// File: rtl/commit_probe.sv
// Commit probe: shadow GPRs, ebreak drain/halt FSM, retire/cycle counters, commit-stall timeout.
// Define COMMIT_PROBE_TRACE_EN to add an 8-entry ring buffer of committed PCs.
module commit_probe
  import commit_probe_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NR_GPR       = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int TIMEOUT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_probe_if.slave          bus,
  output logic [NR_GPR*XLEN-1:0] rf_flat,
  output logic                   is_break,
  output logic                   halt_timeout,
  output logic [XLEN-1:0]        halt_code,
  output logic [XLEN-1:0]        halt_pc,
  output logic [63:0]            inst_cnt,
  output logic [63:0]            cycle_cnt
`ifdef COMMIT_PROBE_TRACE_EN
  ,
  output logic [TRACE_DEPTH*XLEN-1:0] trace_flat,
  output logic [2:0]                  trace_wptr
`endif
);

  localparam int          A0_LSB     = int'(REG_A0) * XLEN;
  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_ready;
  logic            w_accept;
  logic            w_ebreak;
  logic            w_timeout;
  logic [3:0]      r_drain;
  logic [31:0]     r_idle;
  logic [31:0]     w_idle_nxt;
  logic [XLEN-1:0] r_last_pc;
  logic [XLEN-1:0] r_halt_code;
  logic [XLEN-1:0] r_halt_pc;
  logic            r_halt_timeout;
  logic [63:0]     r_inst_cnt;
  logic [63:0]     r_cycle_cnt;
  logic [NR_GPR*XLEN-1:0] w_rf_flat;

  assign w_idle_nxt = r_idle + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An accepted commit clears the idle counter, so ebreak beats a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_ebreak    = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      RUN: begin
        w_ready   = 1'b1;
        w_accept  = bus.cmt_valid;
        w_ebreak  = w_accept && (bus.cmt_inst == INST_EBREAK);
        w_timeout = (TIMEOUT != 0) && !w_accept && (w_idle_nxt == 32'(TIMEOUT));
        if (w_ebreak) begin
          w_state_nxt = DRAIN;
        end else if (w_timeout) begin
          w_state_nxt = HALT;
        end
      end
      DRAIN: begin
        if (r_drain == 4'd0) begin
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  commit_probe_gprs #(
    .XLEN   (XLEN),
    .NR_GPR (NR_GPR)
  ) u_gprs (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_accept && bus.cmt_wen),
    .i_rd      (bus.cmt_rd),
    .i_wdata   (bus.cmt_wdata),
    .o_rf_flat (w_rf_flat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain        <= '0;
      r_idle         <= '0;
      r_last_pc      <= '0;
      r_halt_code    <= '0;
      r_halt_pc      <= '0;
      r_halt_timeout <= 1'b0;
      r_inst_cnt     <= '0;
      r_cycle_cnt    <= '0;
    end else begin
      if (r_state != HALT) begin
        r_cycle_cnt <= r_cycle_cnt + 64'd1;
      end
      if (w_accept) begin
        r_inst_cnt <= r_inst_cnt + 64'd1;
        r_last_pc  <= bus.cmt_pc;
        r_idle     <= '0;
      end else if (r_state == RUN) begin
        r_idle <= w_idle_nxt;
      end
      if (w_ebreak) begin
        r_halt_pc   <= bus.cmt_pc;
        r_halt_code <= w_rf_flat[A0_LSB +: XLEN];
        r_drain     <= DRAIN_LOAD;
      end else if ((r_state == DRAIN) && (r_drain != 4'd0)) begin
        r_drain <= r_drain - 4'd1;
      end
      if (w_timeout) begin
        r_halt_timeout <= 1'b1;
        r_halt_pc      <= r_last_pc;
        r_halt_code    <= w_rf_flat[A0_LSB +: XLEN];
      end
    end
  end

  assign bus.cmt_ready = w_ready;
  assign rf_flat       = w_rf_flat;
  assign is_break      = (r_state == HALT);
  assign halt_timeout  = r_halt_timeout;
  assign halt_code     = r_halt_code;
  assign halt_pc       = r_halt_pc;
  assign inst_cnt      = r_inst_cnt;
  assign cycle_cnt     = r_cycle_cnt;

`ifdef COMMIT_PROBE_TRACE_EN
  // Writes only on accepted commits, so the ring freezes once draining starts.
  logic [XLEN-1:0] r_trace [TRACE_DEPTH];
  logic [2:0]      r_wptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TRACE_DEPTH; k++) begin
        r_trace[k] <= '0;
      end
      r_wptr <= '0;
    end else if (w_accept) begin
      r_trace[r_wptr] <= bus.cmt_pc;
      r_wptr          <= r_wptr + 3'd1;
    end
  end

  for (genvar j = 0; j < TRACE_DEPTH; j++) begin : g_trace
    assign trace_flat[j*XLEN +: XLEN] = r_trace[j];
  end
  assign trace_wptr = r_wptr;
`endif

endmodule
